// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage RV64 pipeline.
// A small IDLE/DRAIN machine discards an in-flight fetch before the PC is redirected.
package pipe_hazard_pkg;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [63:0] u64;
endpackage

module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  creg_addr_t  id_rs1,
    input  creg_addr_t  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  creg_addr_t  ex_dst,
    input  logic        ex_redirect,
    input  u64          ex_target,
    input  logic        ibus_busy,
    input  logic        ibus_resp,
    input  logic        dbus_busy,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        stall_idex,
    output logic        stall_exmem,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        bubble_memwb,
    output logic        pc_redirect,
    output u64          pc_target,
    output logic        drop_fetch,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_redirect
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    u64          tgt_q, tgt_d;
    logic        resp_seen_q, resp_seen_d;
    logic [31:0] cnt_stall_q, cnt_stall_d;
    logic [31:0] cnt_redirect_q, cnt_redirect_d;

    logic        rs1_hit;
    logic        rs2_hit;
    logic        lu;
    logic        fetch_settled;

    // x0 is hardwired to zero, so a load targeting it can never hazard.
    always_comb begin
        rs1_hit = id_use_rs1 && (id_rs1 == ex_dst);
        rs2_hit = id_use_rs2 && (id_rs2 == ex_dst);
        lu      = id_valid && ex_valid && ex_memread && (ex_dst != 5'd0)
                  && (rs1_hit || rs2_hit);
    end

    // No fetch can still land in IF/ID once ibus is idle or answering this cycle.
    assign fetch_settled = !ibus_busy || ibus_resp;

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        resp_seen_d  = resp_seen_q;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        stall_exmem  = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        bubble_memwb = 1'b0;
        pc_redirect  = 1'b0;
        drop_fetch   = 1'b0;
        pc_target    = (state_q == DRAIN) ? tgt_q : ex_target;

        if (dbus_busy) begin
            // Whole pipe freezes; EX will re-present any redirect once MEM completes.
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            stall_exmem  = 1'b1;
            bubble_memwb = 1'b1;
            if (state_q == DRAIN) begin
                drop_fetch  = ibus_resp;
                resp_seen_d = resp_seen_q || ibus_resp;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ex_redirect) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        if (fetch_settled) begin
                            pc_redirect = 1'b1;
                            drop_fetch  = ibus_resp;
                        end else begin
                            stall_pc = 1'b1;
                            tgt_d    = ex_target;
                            state_d  = DRAIN;
                        end
                    end else if (lu) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
                DRAIN: begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    drop_fetch = 1'b1;
                    if (ibus_resp || resp_seen_q) begin
                        pc_redirect = 1'b1;
                        resp_seen_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        stall_pc = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Counters wrap naturally at 32 bits.
    always_comb begin
        cnt_stall_d    = cnt_stall_q + {31'd0, stall_pc};
        cnt_redirect_d = cnt_redirect_q + {31'd0, pc_redirect};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            tgt_q          <= '0;
            resp_seen_q    <= 1'b0;
            cnt_stall_q    <= '0;
            cnt_redirect_q <= '0;
        end else begin
            state_q        <= state_d;
            tgt_q          <= tgt_d;
            resp_seen_q    <= resp_seen_d;
            cnt_stall_q    <= cnt_stall_d;
            cnt_redirect_q <= cnt_redirect_d;
        end
    end

    assign cnt_stall    = cnt_stall_q;
    assign cnt_redirect = cnt_redirect_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario-driven bench for pipe_hazard_ctrl: expected outputs are queued per
// cycle and compared against the DUT mid-cycle.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic        ex_valid, ex_memread;
    logic [4:0]  ex_dst;
    logic        ex_redirect;
    logic [63:0] ex_target;
    logic        ibus_busy, ibus_resp, dbus_busy;
    logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic        flush_ifid, flush_idex, bubble_memwb, pc_redirect, drop_fetch;
    logic [63:0] pc_target;
    logic [31:0] cnt_stall, cnt_redirect;

    int n_cmp = 0;
    int n_err = 0;

    // Flag vector: {stall_pc, stall_ifid, stall_idex, stall_exmem,
    //               flush_ifid, flush_idex, bubble_memwb, pc_redirect, drop_fetch}
    localparam logic [8:0] NONE  = 9'b000000000;
    localparam logic [8:0] S_PC  = 9'b100000000;
    localparam logic [8:0] S_IF  = 9'b010000000;
    localparam logic [8:0] S_ID  = 9'b001000000;
    localparam logic [8:0] S_EX  = 9'b000100000;
    localparam logic [8:0] F_IF  = 9'b000010000;
    localparam logic [8:0] F_ID  = 9'b000001000;
    localparam logic [8:0] B_MW  = 9'b000000100;
    localparam logic [8:0] REDIR = 9'b000000010;
    localparam logic [8:0] DROP  = 9'b000000001;
    localparam logic [8:0] MEMSTALL = S_PC | S_IF | S_ID | S_EX | B_MW;

    typedef struct packed {
        logic [8:0]  f;
        logic [63:0] tgt;
        logic [31:0] cs;
        logic [31:0] cr;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_dst(ex_dst),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .ibus_busy(ibus_busy), .ibus_resp(ibus_resp), .dbus_busy(dbus_busy),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .bubble_memwb(bubble_memwb), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .drop_fetch(drop_fetch), .cnt_stall(cnt_stall), .cnt_redirect(cnt_redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, summary not yet printed");
        $fatal(1, "watchdog");
    end

    task automatic clr_in();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_valid = 0; ex_memread = 0; ex_dst = 0; ex_redirect = 0; ex_target = 0;
        ibus_busy = 0; ibus_resp = 0; dbus_busy = 0;
    endtask

    task automatic set_lu(input logic [4:0] dst);
        id_valid = 1; ex_valid = 1; ex_memread = 1; ex_dst = dst;
        id_rs2 = 5'd5; id_use_rs2 = 1;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
    endtask

    // One transaction: queue the expectation for the current inputs, compare mid-cycle,
    // then advance to just after the next rising edge.
    task automatic step(input string name, input logic [8:0] f, input logic [63:0] tgt,
                        input logic [31:0] cs, input logic [31:0] cr);
        exp_t e;
        logic [8:0] obs_f;
        exp_q.push_back('{f: f, tgt: tgt, cs: cs, cr: cr});
        @(negedge clk);
        e = exp_q.pop_front();
        obs_f = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
                 bubble_memwb, pc_redirect, drop_fetch};
        $display("[%0t] %s flags=%b pc_target=%h cnt_stall=%0d cnt_redirect=%0d",
                 $time, name, obs_f, pc_target, cnt_stall, cnt_redirect);
        n_cmp++;
        if (obs_f !== e.f) begin
            n_err++;
            $display("FAIL %s flags: got %b expected %b", name, obs_f, e.f);
        end
        n_cmp++;
        if (pc_target !== e.tgt) begin
            n_err++;
            $display("FAIL %s pc_target: got %h expected %h", name, pc_target, e.tgt);
        end
        n_cmp++;
        if (cnt_stall !== e.cs) begin
            n_err++;
            $display("FAIL %s cnt_stall: got %h expected %h", name, cnt_stall, e.cs);
        end
        n_cmp++;
        if (cnt_redirect !== e.cr) begin
            n_err++;
            $display("FAIL %s cnt_redirect: got %h expected %h", name, cnt_redirect, e.cr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_in();
        reset = 0;
        ex_redirect = 1;
        ex_target = 64'h1234;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        clr_in();
        step("reset_idle", NONE, 64'h0, 0, 0);
        // Enter DRAIN, then reset: the pending redirect must not fire.
        ex_redirect = 1; ex_target = 64'h8000_0500; ibus_busy = 1;
        step("reset_enter_drain", S_PC | F_IF | F_ID, 64'h8000_0500, 0, 0);
        clr_in();
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        ibus_busy = 1; ibus_resp = 1;
        step("reset_drain_abort", NONE, 64'h0, 0, 0);
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu(5'd5);
        step("lu_rs2", S_PC | S_IF | F_ID, 64'h0, 0, 0);
        ex_memread = 0; ex_valid = 0;
        step("lu_resolved", NONE, 64'h0, 1, 0);
        set_lu(5'd0);
        id_rs2 = 5'd0;
        step("lu_x0", NONE, 64'h0, 1, 0);
        set_lu(5'd7);
        id_use_rs2 = 0; id_rs1 = 5'd7; id_use_rs1 = 1;
        step("lu_rs1", S_PC | S_IF | F_ID, 64'h0, 1, 0);
        id_use_rs1 = 0;
        step("lu_rs1_unused", NONE, 64'h0, 2, 0);
        set_lu(5'd5);
        id_valid = 0;
        step("lu_id_invalid", NONE, 64'h0, 2, 0);
    endtask

    task automatic test_idle_redirect();
        do_reset();
        ex_redirect = 1; ex_target = 64'h8000_0100;
        step("redir_idle", F_IF | F_ID | REDIR, 64'h8000_0100, 0, 0);
        clr_in();
        step("redir_idle_after", NONE, 64'h0, 0, 1);
        // Redirect while the fetch response returns: no drain, but drop it.
        ex_redirect = 1; ex_target = 64'h8000_0180; ibus_busy = 1; ibus_resp = 1;
        step("redir_resp", F_IF | F_ID | REDIR | DROP, 64'h8000_0180, 0, 1);
        // Back-to-back redirect combined with load-use: redirect wins.
        clr_in();
        ex_redirect = 1; ex_target = 64'h8000_01C0; set_lu(5'd5);
        step("redir_vs_lu", F_IF | F_ID | REDIR, 64'h8000_01C0, 0, 2);
        clr_in();
        step("redir_b2b_after", NONE, 64'h0, 0, 3);
    endtask

    task automatic test_drain();
        do_reset();
        ex_redirect = 1; ex_target = 64'h8000_0200; ibus_busy = 1;
        step("drain_enter", S_PC | F_IF | F_ID, 64'h8000_0200, 0, 0);
        ex_redirect = 0; ex_target = 64'hDEAD_BEEF;
        step("drain_wait1", S_PC | F_IF | F_ID | DROP, 64'h8000_0200, 1, 0);
        step("drain_wait2", S_PC | F_IF | F_ID | DROP, 64'h8000_0200, 2, 0);
        ibus_resp = 1;
        step("drain_resp", F_IF | F_ID | DROP | REDIR, 64'h8000_0200, 3, 0);
        ibus_busy = 0; ibus_resp = 0;
        step("drain_done", NONE, 64'hDEAD_BEEF, 3, 1);
    endtask

    task automatic test_mem_stall();
        do_reset();
        dbus_busy = 1; ex_redirect = 1; ex_target = 64'h8000_0300; set_lu(5'd5);
        step("mem_prio1", MEMSTALL, 64'h8000_0300, 0, 0);
        step("mem_prio2", MEMSTALL, 64'h8000_0300, 1, 0);
        dbus_busy = 0;
        step("mem_release_redir", F_IF | F_ID | REDIR, 64'h8000_0300, 2, 0);
        clr_in();
        step("mem_after", NONE, 64'h0, 2, 1);
        // Fetch response lands during a memory stall while draining.
        do_reset();
        ex_redirect = 1; ex_target = 64'h8000_0400; ibus_busy = 1;
        step("mem_drain_enter", S_PC | F_IF | F_ID, 64'h8000_0400, 0, 0);
        clr_in();
        dbus_busy = 1; ibus_busy = 1; ibus_resp = 1;
        step("mem_drain_resp", MEMSTALL | DROP, 64'h8000_0400, 1, 0);
        ibus_busy = 0; ibus_resp = 0;
        step("mem_drain_hold", MEMSTALL, 64'h8000_0400, 2, 0);
        dbus_busy = 0;
        step("mem_drain_fire", F_IF | F_ID | DROP | REDIR, 64'h8000_0400, 3, 0);
        step("mem_drain_done", NONE, 64'h0, 3, 1);
    endtask

    task automatic test_counter_wrap();
        do_reset();
        force dut.cnt_stall_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_stall_q;
        set_lu(5'd5);
        step("wrap_at_max", S_PC | S_IF | F_ID, 64'h0, 32'hFFFF_FFFF, 0);
        clr_in();
        step("wrap_to_zero", NONE, 64'h0, 32'h0, 0);
    endtask

    initial begin
        reset = 0;
        clr_in();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_idle_redirect();
        test_drain();
        test_mem_stall();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RV64 pipeline. Each cycle it decides which pipeline registers hold, which are bubbled, and when the PC is redirected. Inputs are load-use hazards seen between ID and EX, branch/jump resolution in EX, and outstanding ibus/dbus transactions. A two-state machine drains an in-flight fetch after a redirect, so a stale instruction never enters IF/ID. Two 32-bit counters record stall and redirect activity.

## Interface
- No parameters. Register index width is 5 (`creg_addr_t`); addresses are 64-bit (`u64`).
- `clk  in  1  ` clock, all state updates on rising edge.
- `reset  in  1  ` synchronous, active-low: `reset==0` at a rising edge resets the block.
- `id_valid  in  1  ` ID stage holds a valid instruction.
- `id_rs1, id_rs2  in  5  ` ID source register indices.
- `id_use_rs1, id_use_rs2  in  1  ` ID instruction actually reads rs1/rs2.
- `ex_valid  in  1  ` EX stage holds a valid instruction.
- `ex_memread  in  1  ` EX instruction is a load (`ctl.MemRead`).
- `ex_dst  in  5  ` EX destination register.
- `ex_redirect  in  1  ` EX resolved taken branch, jal or jalr.
- `ex_target  in  64  ` redirect PC from EX.
- `ibus_busy  in  1  ` fetch request outstanding this cycle.
- `ibus_resp  in  1  ` fetch response returns this cycle.
- `dbus_busy  in  1  ` data-memory access outstanding (MEM not done).
- `stall_pc, stall_ifid, stall_idex, stall_exmem  out  1  ` hold the register.
- `flush_ifid, flush_idex  out  1  ` load a bubble (`valid=0`) into the register.
- `bubble_memwb  out  1  ` MEM/WB receives `valid=0`.
- `pc_redirect  out  1  ` PC loads `pc_target` this edge.
- `pc_target  out  64  ` redirect address.
- `drop_fetch  out  1  ` IF must mark the returning instruction invalid.
- `cnt_stall, cnt_redirect  out  32  ` performance counters.

## Operation
- States: IDLE, DRAIN. The `tgt_q` register (64 bits) holds the latched target.
- Load-use hazard `lu` = `id_valid & ex_valid & ex_memread & ex_dst!=0 & ((id_use_rs1 & id_rs1==ex_dst) | (id_use_rs2 & id_rs2==ex_dst))`. x0 never hazards.
- Priority: memory stall > redirect > load-use.
- Memory stall (`dbus_busy=1`, any state):
  - `stall_pc`, `stall_ifid`, `stall_idex`, `stall_exmem` = 1; `bubble_memwb` = 1.
  - All flushes, `pc_redirect` and `drop_fetch` = 0, except that in DRAIN `drop_fetch` follows `ibus_resp`.
  - State holds, except that DRAIN records `ibus_resp` into `resp_seen_q`.
  - `ex_redirect` is ignored; EX is frozen, so the redirect is re-presented later.
- IDLE, `ex_redirect=1`, and (`ibus_busy=0` or `ibus_resp=1`):
  - `pc_redirect=1`, `pc_target=ex_target`, `flush_ifid=1`, `flush_idex=1`.
  - `drop_fetch = ibus_resp`. State stays IDLE.
- IDLE, `ex_redirect=1`, `ibus_busy=1`, `ibus_resp=0`:
  - `tgt_q <= ex_target`; go to DRAIN.
  - `flush_ifid=1`, `flush_idex=1`, `stall_pc=1`, `pc_redirect=0`.
- IDLE, `lu=1` (no redirect): `stall_pc=1`, `stall_ifid=1`, `flush_idex=1`.
- DRAIN (no memory stall):
  - `stall_pc=1`, `flush_ifid=1`, `flush_idex=1`, `drop_fetch=1`.
  - When `ibus_resp=1` or `resp_seen_q=1`: `pc_redirect=1`, `pc_target=tgt_q`, `stall_pc=0`, clear `resp_seen_q`, go to IDLE.
  - A new `ex_redirect` in DRAIN is impossible (EX holds a bubble). It is ignored.
- In DRAIN, `pc_target = tgt_q`. In IDLE, `pc_target = ex_target`.
- Counters:
  - `cnt_stall` +1 in every cycle `stall_pc=1`.
  - `cnt_redirect` +1 in every cycle `pc_redirect=1`.
  - Both wrap from 0xFFFF_FFFF to 0.
- Outputs are combinational (Mealy) from state and inputs. State, `tgt_q`, `resp_seen_q` and the counters are registered.

## Timing
- Reset (`reset=0` at an edge): state IDLE, `tgt_q=0`, `resp_seen_q=0`, both counters 0. With no hazards, every output reads 0.
- Reset asserted in DRAIN aborts the pending redirect; it is not replayed.
- Load-use costs exactly 1 bubble. In the next cycle the load is in MEM and `lu=0`.
- Redirect with an idle ibus: 0 extra cycles in the controller; 2 bubbles (IF/ID and ID/EX).
- Redirect with a busy ibus: DRAIN lasts until the response cycle. The redirect fires in the response cycle itself, or in the first cycle after `dbus_busy` falls if the response came during a memory stall.
- Simultaneous `ex_redirect` and `lu`: redirect wins; `stall_ifid=0`.
- Simultaneous `dbus_busy` and `ex_redirect`: only the stall is applied.

## Test plan
- Reset: hold `reset=0` for 2 cycles with `ex_redirect=1` -> after release, all outputs 0, `cnt_stall=0`, `cnt_redirect=0`.
- Load-use: `ex_memread=1`, `ex_dst=5`, `id_rs2=5`, `id_use_rs2=1`, both valid -> for one cycle `stall_pc=stall_ifid=flush_idex=1`. Same stimulus with `ex_dst=0` -> no stall.
- Idle redirect: `ex_redirect=1`, `ex_target=0x80000100`, `ibus_busy=0` -> same cycle `pc_redirect=1`, `pc_target=0x80000100`, both flushes 1, `cnt_redirect=1` next cycle.
- Drain: redirect to 0x80000200 while `ibus_busy=1`; `ibus_resp` arrives 3 cycles later -> DRAIN for 3 cycles with `drop_fetch=1` and `stall_pc=1`, then `pc_redirect=1`, `pc_target=0x80000200` in the response cycle, `cnt_stall=3`.
- Memory stall priority: `dbus_busy=1` together with `ex_redirect=1` and `lu=1` -> only the four stalls and `bubble_memwb` are 1. After `dbus_busy` drops, the redirect fires.
- Counter wrap: preload through 2^32 stall cycles (or force the counter) -> `cnt_stall` goes from 0xFFFFFFFF to 0.
